// File: rtl/map_renderer_pkg.sv
// Shared definitions for the map renderer and its sprite palette:
// default geometry, sprite codes, 3-bit RGB colours and the renderer state enum.
package map_renderer_pkg;

    // Default geometry; the top-level parameters take these as their defaults.
    localparam int DEF_MAP_W   = 21;
    localparam int DEF_MAP_H   = 21;
    localparam int DEF_TILE_PX = 4;
    localparam int DEF_RD_LAT  = 2;

    // Sprite codes returned by the map controller.
    localparam logic [2:0] SPR_EMPTY  = 3'd0;
    localparam logic [2:0] SPR_WALL   = 3'd1;
    localparam logic [2:0] SPR_PELLET = 3'd2;
    localparam logic [2:0] SPR_PACMAN = 3'd3;
    localparam logic [2:0] SPR_GHOST  = 3'd4;
    localparam logic [2:0] SPR_POWER  = 3'd5;

    // Colours, one bit per channel in R,G,B order.
    localparam logic [2:0] COL_BLACK  = 3'b000;
    localparam logic [2:0] COL_BLUE   = 3'b001;
    localparam logic [2:0] COL_WHITE  = 3'b111;
    localparam logic [2:0] COL_YELLOW = 3'b110;
    localparam logic [2:0] COL_RED    = 3'b100;

    // Renderer sequencing states.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        WAIT = 3'd2,
        DRAW = 3'd3,
        NEXT = 3'd4,
        DONE = 3'd5
    } render_state_t;

endpackage

// File: rtl/map_renderer_sprite_palette.sv
// sprite_palette: combinational mapping from a sprite code and the pixel
// position inside its tile to a 3-bit colour. Shared with the HUD drawer.
module sprite_palette
    import map_renderer_pkg::*;
#(
    parameter  int TILE_PX = DEF_TILE_PX,
    localparam int PX_W    = $clog2(TILE_PX)
) (
    input  logic [2:0]      sprite,
    input  logic [PX_W-1:0] px,
    input  logic [PX_W-1:0] py,
    output logic [2:0]      colour
);

    logic inner_s;

    // Pellets light only the inner pixels so they read as a dot, not a block.
    always_comb begin
        colour  = COL_BLACK;
        inner_s = (px != {PX_W{1'b0}}) && (px != PX_W'(TILE_PX - 1)) &&
                  (py != {PX_W{1'b0}}) && (py != PX_W'(TILE_PX - 1));
        case (sprite)
            SPR_EMPTY:  colour = COL_BLACK;
            SPR_WALL:   colour = COL_BLUE;
            SPR_PELLET: begin
                if (inner_s) begin
                    colour = COL_WHITE;
                end else begin
                    colour = COL_BLACK;
                end
            end
            SPR_PACMAN: colour = COL_YELLOW;
            SPR_GHOST:  colour = COL_RED;
            SPR_POWER:  colour = COL_WHITE;
            default:    colour = COL_BLACK;
        endcase
    end

endmodule

// File: rtl/map_renderer.sv
// map_renderer: walks every tile of the sprite map through the map controller
// read port and expands each sprite into a TILE_PX x TILE_PX block of pixel
// writes. One frame per start pulse, one-cycle done pulse at the end.
// Build option: MAP_RENDER_SKIP_EMPTY_EN - empty tiles skip the draw phase
// (no plots, 2+RD_LAT cycles per empty tile). Without it, empty tiles are
// drawn black so stale pixels get cleared.
module map_renderer
    import map_renderer_pkg::*;
#(
    parameter int MAP_W   = DEF_MAP_W,
    parameter int MAP_H   = DEF_MAP_H,
    parameter int TILE_PX = DEF_TILE_PX,
    parameter int RD_LAT  = DEF_RD_LAT
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [4:0] map_x,
    output logic [4:0] map_y,
    output logic       readWrite,
    input  logic [2:0] spriteOut,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] colour,
    output logic       plot
);

    localparam int PX_W   = $clog2(TILE_PX);
    localparam int WAIT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    // Reject geometries that do not fit the screen or the tile counters.
    if ((MAP_W * TILE_PX) > 256 || (MAP_H * TILE_PX) > 128 ||
        TILE_PX < 2 || (TILE_PX & (TILE_PX - 1)) != 0 ||
        RD_LAT < 1 || MAP_W > 32 || MAP_H > 32) begin : g_bad_params
        $error("map_renderer: unsupported MAP_W/MAP_H/TILE_PX/RD_LAT combination");
    end

    render_state_t     state_r, state_nxt_s;
    logic [PX_W-1:0]   px_r, px_nxt_s;
    logic [PX_W-1:0]   py_r, py_nxt_s;
    logic [WAIT_W-1:0] wait_cnt_r, wait_nxt_s;
    logic [2:0]        sprite_q_r, sprite_nxt_s;
    logic [4:0]        map_x_r, map_x_nxt_s;
    logic [4:0]        map_y_r, map_y_nxt_s;

    logic              busy_r, done_r, plot_r;
    logic [7:0]        vga_x_r;
    logic [6:0]        vga_y_r;
    logic [2:0]        colour_r;

    logic              busy_nxt_s, done_nxt_s, plot_nxt_s;
    logic [8:0]        pix_x_s, pix_y_s;
    logic [2:0]        palette_colour_s;

    // Next-state, tile walk and pixel counters.
    always_comb begin
        state_nxt_s  = state_r;
        px_nxt_s     = px_r;
        py_nxt_s     = py_r;
        wait_nxt_s   = wait_cnt_r;
        sprite_nxt_s = sprite_q_r;
        map_x_nxt_s  = map_x_r;
        map_y_nxt_s  = map_y_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = ADDR;
                    map_x_nxt_s = 5'd0;
                    map_y_nxt_s = 5'd0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ADDR: begin
                state_nxt_s = WAIT;
                wait_nxt_s  = {WAIT_W{1'b0}};
            end
            WAIT: begin
                if (wait_cnt_r == WAIT_W'(RD_LAT - 1)) begin
                    sprite_nxt_s = spriteOut;
                    px_nxt_s     = {PX_W{1'b0}};
                    py_nxt_s     = {PX_W{1'b0}};
`ifdef MAP_RENDER_SKIP_EMPTY_EN
                    if (spriteOut == SPR_EMPTY) begin
                        state_nxt_s = NEXT;
                    end else begin
                        state_nxt_s = DRAW;
                    end
`else
                    state_nxt_s  = DRAW;
`endif
                end else begin
                    wait_nxt_s = wait_cnt_r + WAIT_W'(1);
                end
            end
            DRAW: begin
                if (px_r == PX_W'(TILE_PX - 1)) begin
                    px_nxt_s = {PX_W{1'b0}};
                    if (py_r == PX_W'(TILE_PX - 1)) begin
                        py_nxt_s    = {PX_W{1'b0}};
                        state_nxt_s = NEXT;
                    end else begin
                        py_nxt_s = py_r + PX_W'(1);
                    end
                end else begin
                    px_nxt_s = px_r + PX_W'(1);
                end
            end
            NEXT: begin
                if (map_x_r == 5'(MAP_W - 1)) begin
                    map_x_nxt_s = 5'd0;
                    if (map_y_r == 5'(MAP_H - 1)) begin
                        // Last tile: park the read address back at the origin.
                        map_y_nxt_s = 5'd0;
                        state_nxt_s = DONE;
                    end else begin
                        map_y_nxt_s = map_y_r + 5'd1;
                        state_nxt_s = ADDR;
                    end
                end else begin
                    map_x_nxt_s = map_x_r + 5'd1;
                    state_nxt_s = ADDR;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Output values are derived from the next state so every port is a flop.
    always_comb begin
        busy_nxt_s = (state_nxt_s != IDLE);
        done_nxt_s = (state_nxt_s == DONE);
        plot_nxt_s = (state_nxt_s == DRAW);
        pix_x_s    = 9'(map_x_nxt_s) * 9'(TILE_PX) + 9'(px_nxt_s);
        pix_y_s    = 9'(map_y_nxt_s) * 9'(TILE_PX) + 9'(py_nxt_s);
    end

    sprite_palette #(
        .TILE_PX (TILE_PX)
    ) u_palette (
        .sprite (sprite_nxt_s),
        .px     (px_nxt_s),
        .py     (py_nxt_s),
        .colour (palette_colour_s)
    );

    // Sequencer state, counters and tile address registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r    <= IDLE;
            px_r       <= {PX_W{1'b0}};
            py_r       <= {PX_W{1'b0}};
            wait_cnt_r <= {WAIT_W{1'b0}};
            sprite_q_r <= 3'd0;
            map_x_r    <= 5'd0;
            map_y_r    <= 5'd0;
        end else begin
            state_r    <= state_nxt_s;
            px_r       <= px_nxt_s;
            py_r       <= py_nxt_s;
            wait_cnt_r <= wait_nxt_s;
            sprite_q_r <= sprite_nxt_s;
            map_x_r    <= map_x_nxt_s;
            map_y_r    <= map_y_nxt_s;
        end
    end

    // Registered status and pixel outputs; pixel data only moves when plotting.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            plot_r   <= 1'b0;
            vga_x_r  <= 8'd0;
            vga_y_r  <= 7'd0;
            colour_r <= 3'd0;
        end else begin
            busy_r <= busy_nxt_s;
            done_r <= done_nxt_s;
            plot_r <= plot_nxt_s;
            if (plot_nxt_s) begin
                vga_x_r  <= 8'(pix_x_s);
                vga_y_r  <= 7'(pix_y_s);
                colour_r <= palette_colour_s;
            end else begin
                vga_x_r  <= vga_x_r;
                vga_y_r  <= vga_y_r;
                colour_r <= colour_r;
            end
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign plot      = plot_r;
    assign map_x     = map_x_r;
    assign map_y     = map_y_r;
    assign vga_x     = vga_x_r;
    assign vga_y     = vga_y_r;
    assign colour    = colour_r;
    assign readWrite = 1'b0;

endmodule
